// File: rtl/button_conditioner_if.sv
// Signal bundle between one raw button pin and its conditioner.
// The slave side is the conditioner; the master side drives the pin and consumes the strobes.
interface button_conditioner_if;
   logic       btn_raw;
   logic       level;
   logic       press;
   logic       release_pulse;
   logic       long_press;
   logic       repeat_pulse;
   logic [1:0] dbg_state;

   // Strobe semantics: press/release_pulse/long_press/repeat_pulse are single-cycle,
   // registered pulses; level is a registered steady value. There is no back-pressure.
   modport master (
      output btn_raw,
      input  level,
      input  press,
      input  release_pulse,
      input  long_press,
      input  repeat_pulse,
      input  dbg_state
   );

   modport slave (
      input  btn_raw,
      output level,
      output press,
      output release_pulse,
      output long_press,
      output repeat_pulse,
      output dbg_state
   );
endinterface

// File: rtl/button_conditioner.sv
// Push-button front end: 2-FF synchronizer, debounce FSM and registered
// press/release/long-press/auto-repeat strobes.
module button_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned LONG_CYCLES     = 25000000,
   parameter int unsigned REPEAT_CYCLES   = 2500000,
   parameter bit          ACTIVE_LOW      = 1'b0
) (
   input logic                 clk_25mhz,
   input logic                 rst_n,
   button_conditioner_if.slave btn_if
);

   localparam int unsigned REP_EFF = (REPEAT_CYCLES > 0) ? REPEAT_CYCLES : 1;
   localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES);
   localparam int unsigned HOLD_W  = $clog2(LONG_CYCLES + REP_EFF);
   localparam int unsigned REP_W   = (REP_EFF > 1) ? $clog2(REP_EFF) : 1;

   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
   localparam logic [HOLD_W-1:0] LONG_DONE = HOLD_W'(LONG_CYCLES);
   localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REP_EFF - 1);
   localparam logic              PIN_IDLE  = ACTIVE_LOW;

   typedef enum logic [1:0] {
      ST_RELEASED   = 2'd0,
      ST_DB_PRESS   = 2'd1,
      ST_PRESSED    = 2'd2,
      ST_DB_RELEASE = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic              sync1_q, sync2_q;
   logic [DB_W-1:0]   db_q, db_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [REP_W-1:0]  rep_q, rep_d;
   logic              level_q, level_d;
   logic              press_q, press_d;
   logic              release_q, release_d;
   logic              long_q, long_d;
   logic              repeat_q, repeat_d;
   logic              act;

   assign act = sync2_q ^ ACTIVE_LOW;

   always_ff @(posedge clk_25mhz or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= PIN_IDLE;
         sync2_q   <= PIN_IDLE;
         state_q   <= ST_RELEASED;
         db_q      <= '0;
         hold_q    <= '0;
         rep_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
         repeat_q  <= 1'b0;
      end else begin
         sync1_q   <= btn_if.btn_raw;
         sync2_q   <= sync1_q;
         state_q   <= state_d;
         db_q      <= db_d;
         hold_q    <= hold_d;
         rep_q     <= rep_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         long_q    <= long_d;
         repeat_q  <= repeat_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      db_d      = db_q;
      hold_d    = hold_q;
      rep_d     = rep_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      long_d    = 1'b0;
      repeat_d  = 1'b0;

      case (state_q)
         ST_RELEASED: begin
            if (act) begin
               state_d = ST_DB_PRESS;
               db_d    = '0;
            end
         end

         ST_DB_PRESS: begin
            if (!act) begin
               state_d = ST_RELEASED;
               db_d    = '0;
            end else if (db_q == DB_LAST) begin
               state_d = ST_PRESSED;
               press_d = 1'b1;
               hold_d  = '0;
               rep_d   = '0;
            end else begin
               db_d = db_q + 1'b1;
            end
         end

         ST_PRESSED: begin
            // hold_q parks at LONG_DONE once long_press has fired; rep_q then paces repeats.
            if (hold_q < LONG_LAST) begin
               hold_d = hold_q + 1'b1;
            end else if (hold_q == LONG_LAST) begin
               long_d = 1'b1;
               hold_d = LONG_DONE;
               rep_d  = '0;
            end else if (REPEAT_CYCLES != 0) begin
               if (rep_q == REP_LAST) begin
                  repeat_d = 1'b1;
                  rep_d    = '0;
               end else begin
                  rep_d = rep_q + 1'b1;
               end
            end
            if (!act) begin
               state_d = ST_DB_RELEASE;
               db_d    = '0;
            end
         end

         ST_DB_RELEASE: begin
            if (act) begin
               state_d = ST_PRESSED;
            end else if (db_q == DB_LAST) begin
               state_d   = ST_RELEASED;
               release_d = 1'b1;
               hold_d    = '0;
               rep_d     = '0;
            end else begin
               db_d = db_q + 1'b1;
            end
         end

         default: begin
            state_d = ST_RELEASED;
         end
      endcase

      level_d = (state_d == ST_PRESSED) || (state_d == ST_DB_RELEASE);
   end

   assign btn_if.level         = level_q;
   assign btn_if.press         = press_q;
   assign btn_if.release_pulse = release_q;
   assign btn_if.long_press    = long_q;
   assign btn_if.repeat_pulse  = repeat_q;
   assign btn_if.dbg_state     = state_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: one active-high and one active-low instance
// sharing clock and reset, with per-cycle hand-computed strobe expectations.
module tb_button_conditioner;
   localparam int DB   = 4;
   localparam int LONG = 20;
   localparam int REP  = 5;

   logic clk_25mhz = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   button_conditioner_if if0 ();
   button_conditioner_if if1 ();

   button_conditioner #(
      .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .ACTIVE_LOW(1'b0)
   ) dut0 (
      .clk_25mhz(clk_25mhz), .rst_n(rst_n), .btn_if(if0.slave)
   );

   button_conditioner #(
      .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .ACTIVE_LOW(1'b1)
   ) dut1 (
      .clk_25mhz(clk_25mhz), .rst_n(rst_n), .btn_if(if1.slave)
   );

   always #20 clk_25mhz = ~clk_25mhz;

   // Output vector layout: {level, press, release, long_press, repeat}
   function automatic logic [4:0] obs0();
      return {if0.level, if0.press, if0.release_pulse, if0.long_press, if0.repeat_pulse};
   endfunction

   function automatic logic [4:0] obs1();
      return {if1.level, if1.press, if1.release_pulse, if1.long_press, if1.repeat_pulse};
   endfunction

   task automatic tick();
      @(posedge clk_25mhz);
      #1;
   endtask

   task automatic test_reset();
      logic [4:0] got;
      rst_n = 1'b0;
      if0.btn_raw = 1'b0;
      if1.btn_raw = 1'b1;
      repeat (3) tick();
      got = obs0();
      checks++;
      if (got !== 5'b00000) begin
         errors++;
         $display("FAIL reset_dut0 got=%b exp=%b", got, 5'b00000);
      end
      got = obs1();
      checks++;
      if (got !== 5'b00000) begin
         errors++;
         $display("FAIL reset_dut1 got=%b exp=%b", got, 5'b00000);
      end
      rst_n = 1'b1;
      for (int e = 0; e < 8; e++) begin
         tick();
         got = obs0();
         checks++;
         if (got !== 5'b00000) begin
            errors++;
            $display("FAIL idle_dut0 e=%0d got=%b exp=%b", e, got, 5'b00000);
         end
         got = obs1();
         checks++;
         if (got !== 5'b00000) begin
            errors++;
            $display("FAIL idle_dut1 e=%0d got=%b exp=%b", e, got, 5'b00000);
         end
      end
   endtask

   task automatic test_clean_press();
      logic [4:0] got, exp;
      if0.btn_raw = 1'b1;
      for (int e = 0; e < 26; e++) begin
         tick();
         exp = '0;
         exp[4] = (e >= 6);
         exp[3] = (e == 6);
         got = obs0();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL clean_press e=%0d got=%b exp=%b", e, got, exp);
         end
      end
   endtask

   // Continues the hold started by test_clean_press: edges 26..47 after the step.
   task automatic test_long_repeat();
      logic [4:0] got, exp;
      for (int e = 26; e < 48; e++) begin
         tick();
         exp = '0;
         exp[4] = 1'b1;
         exp[1] = (e == 26);
         exp[0] = (e == 31) || (e == 36) || (e == 41) || (e == 46);
         got = obs0();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL long_repeat e=%0d got=%b exp=%b", e, got, exp);
         end
      end
      if0.btn_raw = 1'b0;
      for (int r = 0; r < 10; r++) begin
         tick();
         exp = '0;
         exp[4] = (r < 6);
         exp[2] = (r == 6);
         got = obs0();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL release_after_repeat r=%0d got=%b exp=%b", r, got, exp);
         end
      end
   endtask

   task automatic test_bounce_reject();
      logic [4:0]  got, exp;
      logic [11:0] pat;
      pat = 12'b0011_1001_1001;
      for (int e = 0; e < 25; e++) begin
         if0.btn_raw = (e < 12) ? pat[e] : 1'b1;
         tick();
         exp = '0;
         exp[4] = (e >= 18);
         exp[3] = (e == 18);
         got = obs0();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL bounce_reject e=%0d got=%b exp=%b", e, got, exp);
         end
      end
      if0.btn_raw = 1'b0;
      for (int r = 0; r < 10; r++) begin
         tick();
         exp = '0;
         exp[4] = (r < 6);
         exp[2] = (r == 6);
         got = obs0();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL bounce_release r=%0d got=%b exp=%b", r, got, exp);
         end
      end
   endtask

   task automatic test_release_bounce();
      logic [4:0] got, exp;
      for (int e = 0; e < 30; e++) begin
         if0.btn_raw = (e == 11 || e == 12) ? 1'b0 : 1'b1;
         tick();
         exp = '0;
         exp[4] = (e >= 6);
         exp[3] = (e == 6);
         exp[1] = (e == 28);
         got = obs0();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL release_bounce e=%0d got=%b exp=%b", e, got, exp);
         end
      end
      if0.btn_raw = 1'b0;
      for (int r = 0; r < 10; r++) begin
         tick();
         exp = '0;
         exp[4] = (r < 6);
         exp[2] = (r == 6);
         got = obs0();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL release_bounce_end r=%0d got=%b exp=%b", r, got, exp);
         end
      end
   endtask

   task automatic test_active_low();
      logic [4:0] got, exp;
      if1.btn_raw = 1'b0;
      for (int e = 0; e < 10; e++) begin
         tick();
         exp = '0;
         exp[4] = (e >= 6);
         exp[3] = (e == 6);
         got = obs1();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL active_low_press e=%0d got=%b exp=%b", e, got, exp);
         end
      end
      if1.btn_raw = 1'b1;
      for (int r = 0; r < 10; r++) begin
         tick();
         exp = '0;
         exp[4] = (r < 6);
         exp[2] = (r == 6);
         got = obs1();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL active_low_release r=%0d got=%b exp=%b", r, got, exp);
         end
      end
   endtask

   task automatic test_reset_mid_hold();
      logic [4:0] got, exp;
      if0.btn_raw = 1'b1;
      for (int e = 0; e < 17; e++) begin
         tick();
         exp = '0;
         exp[4] = (e >= 6);
         exp[3] = (e == 6);
         got = obs0();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL mid_hold_press e=%0d got=%b exp=%b", e, got, exp);
         end
      end
      rst_n = 1'b0;
      #1;
      got = obs0();
      checks++;
      if (got !== 5'b00000) begin
         errors++;
         $display("FAIL async_reset got=%b exp=%b", got, 5'b00000);
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         got = obs0();
         checks++;
         if (got !== 5'b00000) begin
            errors++;
            $display("FAIL in_reset c=%0d got=%b exp=%b", c, got, 5'b00000);
         end
      end
      rst_n = 1'b1;
      for (int e = 0; e < 28; e++) begin
         tick();
         exp = '0;
         exp[4] = (e >= 6);
         exp[3] = (e == 6);
         exp[1] = (e == 26);
         got = obs0();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL after_reset e=%0d got=%b exp=%b", e, got, exp);
         end
      end
      if0.btn_raw = 1'b0;
      for (int r = 0; r < 10; r++) begin
         tick();
         exp = '0;
         exp[4] = (r < 6);
         exp[2] = (r == 6);
         got = obs0();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL after_reset_release r=%0d got=%b exp=%b", r, got, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_long_repeat();
      test_bounce_reject();
      test_release_bounce();
      test_active_low();
      test_reset_mid_hold();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
